// File: rtl/onchip_memory_burst_pkg.sv
// Shared types and constants for the burst-capable on-chip RAM slave.
// OCM_OUTREG_EN adds one output register stage, which changes the read latency.
package onchip_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } ocm_state_e;

    function automatic int ocm_rd_lat();
`ifdef OCM_OUTREG_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    localparam int OCM_RD_LAT = ocm_rd_lat();

endpackage

// File: rtl/onchip_memory_burst_if.sv
// Avalon-MM slave bus bundle for the on-chip RAM. Clock, reset and clken stay as
// plain ports on the modules that use this bundle.
interface onchip_memory_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BC_W   = 4
);
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [BC_W-1:0]       burstcount;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic                  waitrequest;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output chipselect, read, write, address, burstcount, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  chipselect, read, write, address, burstcount, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_burst_array.sv
// Single-port byte-enabled RAM with a registered read port. Reads return the
// pre-write contents; reset clears only the read register, never the array.
module onchip_mem_array #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "onchip_mem.hex",
    localparam int   ADDR_W    = $clog2(DEPTH),
    localparam int   BE_W      = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)               q_q <= '0;
        else if (en_i && re_i)   q_q <= mem[addr_i];
    end

    assign q_o = q_q;
endmodule

// File: rtl/onchip_memory_burst.sv
// Avalon-MM on-chip RAM slave with incrementing, wrapping read/write bursts.
// Define OCM_OUTREG_EN for an extra output register stage (read latency 2).
module onchip_memory_burst
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    MAX_BURST = 8,
    parameter string INIT_FILE = "onchip_mem.hex"
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clken_i,
    onchip_memory_burst_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BC_W   = $clog2(MAX_BURST) + 1;

    ocm_state_e        state_q, state_d;
    logic [BC_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid_q;

    logic              active, waitreq, accept, wbeat;
    logic [BC_W-1:0]   n_eff;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign active  = clken_i & ~reset_i;
    assign waitreq = reset_i | ~clken_i | (state_q == RBURST);
    assign accept  = bus.chipselect & (bus.read | bus.write) & ~waitreq;
    assign wbeat   = bus.chipselect & bus.write & ~waitreq;
    assign n_eff   = (bus.burstcount == '0) ? BC_W'(1) : bus.burstcount;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
        end else if (clken_i) begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            rvalid_q <= mem_re;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (n_eff > BC_W'(1))) begin
                    state_d = bus.write ? WBURST : RBURST;
                    rem_d   = n_eff - BC_W'(1);
                    addr_d  = addr_inc(bus.address);
                end
            end
            RBURST: begin
                rem_d  = rem_q - BC_W'(1);
                addr_d = addr_inc(addr_q);
                if (rem_q == BC_W'(1)) state_d = IDLE;
            end
            WBURST: begin
                if (wbeat) begin
                    rem_d  = rem_q - BC_W'(1);
                    addr_d = addr_inc(addr_q);
                    if (rem_q == BC_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write wins over read when both are presented on the same command.
    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                mem_addr = bus.address;
                if (accept && bus.write)     mem_we = 1'b1;
                else if (accept && bus.read) mem_re = 1'b1;
            end
            RBURST:  mem_re = active;
            WBURST:  mem_we = wbeat;
            default: ;
        endcase
    end

    onchip_mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .en_i    (clken_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .be_i    (bus.byteenable),
        .wdata_i (bus.writedata),
        .q_o     (mem_q)
    );

    assign bus.waitrequest = waitreq;

`ifdef OCM_OUTREG_EN
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q   <= '0;
            rvalid2_q <= 1'b0;
        end else if (clken_i) begin
            rdata_q   <= mem_q;
            rvalid2_q <= rvalid_q;
        end
    end

    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rvalid2_q;
`else
    assign bus.readdata      = mem_q;
    assign bus.readdatavalid = rvalid_q;
`endif
endmodule
